// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: fetch FSM states, PC step and the opcodes
// that the fetch unit and the control decoder agree on.
package mips_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] PC_STEP = 32'd4;

    localparam logic [5:0] R_TYPE = 6'b000000;
    localparam logic [5:0] ADDI   = 6'b001000;
    localparam logic [5:0] ORI    = 6'b001101;
    localparam logic [5:0] BEQ    = 6'b000100;
    localparam logic [5:0] BNE    = 6'b000101;

    // Branch offset is a word count: sign-extend and scale to bytes.
    function automatic logic [31:0] sext_branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/mips_fetch_unit_if.sv
// Fetch unit bus: instruction-memory handshake, held-instruction handshake to
// execute, and the decoder/ALU branch inputs.
interface mips_fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [5:0]  opcode;
    logic        instr_ready;
    logic        BranchEQ;
    logic        BranchNE;
    logic        Zero;
    logic [31:0] retired_count;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc, opcode, retired_count,
        input  imem_valid, imem_rdata, instr_ready, BranchEQ, BranchNE, Zero
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, opcode, retired_count,
        output imem_valid, imem_rdata, instr_ready, BranchEQ, BranchNE, Zero
    );

endinterface

// File: rtl/pc_next_calc.sv
// Next-PC selection: sequential pc+4 or the PC-relative branch target.
// All arithmetic wraps modulo 2^32.
module pc_next_calc
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [15:0] imm,
    input  logic        branch_eq,
    input  logic        branch_ne,
    input  logic        zero,
    output logic [31:0] pc_next
);

    logic        taken_s;
    logic [31:0] seq_pc_s;
    logic [31:0] target_pc_s;

    // Both decoder flags set means one of the two terms is always true.
    always_comb begin
        seq_pc_s    = pc + PC_STEP;
        target_pc_s = seq_pc_s + sext_branch_offset(imm);
        taken_s     = (branch_eq & zero) | (branch_ne & ~zero);
        if (taken_s) begin
            pc_next = target_pc_s;
        end else begin
            pc_next = seq_pc_s;
        end
    end

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction fetch and PC sequencing: one request per instruction, holds the
// returned word until execute consumes it, then steps or branches the PC.
module mips_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] PC_RESET   = 32'h0040_0000,
    parameter int          DATA_WIDTH = 32
) (
    input logic               clk,
    input logic               reset,
    mips_fetch_unit_if.master bus
);

    fetch_state_t            state_r;
    logic [DATA_WIDTH-1:0]   pc_r;
    logic                    imem_req_r;
    logic [DATA_WIDTH-1:0]   imem_addr_r;
    logic                    instr_valid_r;
    logic [DATA_WIDTH-1:0]   instr_r;
    logic [DATA_WIDTH-1:0]   instr_pc_r;
    logic [DATA_WIDTH-1:0]   retired_r;
    logic [DATA_WIDTH-1:0]   pc_next_s;

    pc_next_calc u_pc_next_calc (
        .pc        (pc_r),
        .imm       (instr_r[15:0]),
        .branch_eq (bus.BranchEQ),
        .branch_ne (bus.BranchNE),
        .zero      (bus.Zero),
        .pc_next   (pc_next_s)
    );

    // Fetch FSM with all outputs registered. Leaving HOLD raises the next
    // request directly so REQ only has to drop it, giving 3 cycles/instr;
    // the idle request after reset is raised from within REQ instead.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= REQ;
            pc_r          <= PC_RESET;
            imem_req_r    <= 1'b0;
            imem_addr_r   <= PC_RESET;
            instr_valid_r <= 1'b0;
            instr_r       <= 32'd0;
            instr_pc_r    <= 32'd0;
            retired_r     <= 32'd0;
        end else begin
            case (state_r)
                REQ: begin
                    if (!imem_req_r) begin
                        imem_req_r  <= 1'b1;
                        imem_addr_r <= pc_r;
                    end else begin
                        imem_req_r <= 1'b0;
                        state_r    <= WAIT;
                    end
                end
                WAIT: begin
                    imem_req_r <= 1'b0;
                    if (bus.imem_valid) begin
                        instr_r       <= bus.imem_rdata;
                        instr_pc_r    <= pc_r;
                        instr_valid_r <= 1'b1;
                        state_r       <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.instr_ready) begin
                        pc_r          <= pc_next_s;
                        imem_req_r    <= 1'b1;
                        imem_addr_r   <= pc_next_s;
                        instr_valid_r <= 1'b0;
                        retired_r     <= retired_r + 32'd1;
                        state_r       <= REQ;
                    end
                end
                default: begin
                    state_r       <= REQ;
                    imem_req_r    <= 1'b0;
                    instr_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req      = imem_req_r;
    assign bus.imem_addr     = imem_addr_r;
    assign bus.instr_valid   = instr_valid_r;
    assign bus.instr         = instr_r;
    assign bus.instr_pc      = instr_pc_r;
    assign bus.opcode        = instr_r[31:26];
    assign bus.retired_count = retired_r;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit: one instance at the default reset PC,
// one at 32'hFFFF_FFF8 to exercise address wrap.
module tb_mips_fetch_unit;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        instr_ready = 1'b0;
    logic        beq_in = 1'b0;
    logic        bne_in = 1'b0;
    logic        zero_in = 1'b0;
    logic        sel = 1'b0;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mips_fetch_unit_if bus_a ();
    mips_fetch_unit_if bus_b ();

    assign bus_a.imem_valid  = imem_valid;
    assign bus_a.imem_rdata  = imem_rdata;
    assign bus_a.instr_ready = instr_ready;
    assign bus_a.BranchEQ    = beq_in;
    assign bus_a.BranchNE    = bne_in;
    assign bus_a.Zero        = zero_in;
    assign bus_b.imem_valid  = imem_valid;
    assign bus_b.imem_rdata  = imem_rdata;
    assign bus_b.instr_ready = instr_ready;
    assign bus_b.BranchEQ    = beq_in;
    assign bus_b.BranchNE    = bne_in;
    assign bus_b.Zero        = zero_in;

    mips_fetch_unit dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    mips_fetch_unit #(.PC_RESET(32'hFFFF_FFF8)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    logic        obs_req;
    logic [31:0] obs_addr;
    logic        obs_iv;
    logic [31:0] obs_instr;
    logic [31:0] obs_ipc;
    logic [5:0]  obs_op;
    logic [31:0] obs_ret;

    always_comb begin
        obs_req   = sel ? bus_b.imem_req      : bus_a.imem_req;
        obs_addr  = sel ? bus_b.imem_addr     : bus_a.imem_addr;
        obs_iv    = sel ? bus_b.instr_valid   : bus_a.instr_valid;
        obs_instr = sel ? bus_b.instr         : bus_a.instr;
        obs_ipc   = sel ? bus_b.instr_pc      : bus_a.instr_pc;
        obs_op    = sel ? bus_b.opcode        : bus_a.opcode;
        obs_ret   = sel ? bus_b.retired_count : bus_a.retired_count;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Assert reset mid-cycle, check async reset values, release, expect first request.
    task automatic reset_seq(input logic [31:0] rst_pc);
        reset = 1'b0;
        #1;
        chk("rst_req", 32'(obs_req), 32'd0);
        chk("rst_addr", obs_addr, rst_pc);
        chk("rst_iv", 32'(obs_iv), 32'd0);
        chk("rst_instr", obs_instr, 32'd0);
        chk("rst_ipc", obs_ipc, 32'd0);
        chk("rst_ret", obs_ret, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        chk("rel_req_low", 32'(obs_req), 32'd0);
        tick();
        chk("first_req", 32'(obs_req), 32'd1);
        chk("first_addr", obs_addr, rst_pc);
    endtask

    // One complete instruction: request, memory response, hold, consume.
    task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] word,
                         input int vdly, input int rdly,
                         input logic eq, input logic ne, input logic z,
                         input logic [31:0] exp_ret, output int req_cyc);
        int n = 0;
        while (!obs_req && n < 20) begin
            tick();
            n++;
        end
        req_cyc = cyc;
        chk("req_seen", 32'(obs_req), 32'd1);
        chk("req_addr", obs_addr, exp_addr);
        tick();
        chk("req_one_cycle", 32'(obs_req), 32'd0);
        for (int i = 1; i < vdly; i++) begin
            tick();
            chk("wait_no_req", 32'(obs_req), 32'd0);
            chk("wait_iv_low", 32'(obs_iv), 32'd0);
        end
        imem_valid = 1'b1;
        imem_rdata = word;
        tick();
        imem_valid = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        chk("iv_high", 32'(obs_iv), 32'd1);
        chk("instr", obs_instr, word);
        chk("instr_pc", obs_ipc, exp_addr);
        chk("opcode", 32'(obs_op), 32'(word[31:26]));
        for (int i = 0; i < rdly; i++) begin
            tick();
            chk("hold_instr", obs_instr, word);
            chk("hold_pc", obs_ipc, exp_addr);
            chk("hold_no_req", 32'(obs_req), 32'd0);
            chk("hold_ret", obs_ret, exp_ret - 32'd1);
        end
        instr_ready = 1'b1;
        beq_in = eq;
        bne_in = ne;
        zero_in = z;
        tick();
        instr_ready = 1'b0;
        beq_in = 1'b0;
        bne_in = 1'b0;
        zero_in = 1'b0;
        chk("iv_cleared", 32'(obs_iv), 32'd0);
        chk("retired", obs_ret, exp_ret);
    endtask

    // Request and receive a word, leaving it held (no consume).
    task automatic fetch_to_hold(input logic [31:0] exp_addr, input logic [31:0] word);
        int n = 0;
        while (!obs_req && n < 20) begin
            tick();
            n++;
        end
        chk("hold_req_seen", 32'(obs_req), 32'd1);
        chk("hold_req_addr", obs_addr, exp_addr);
        tick();
        imem_valid = 1'b1;
        imem_rdata = word;
        tick();
        imem_valid = 1'b0;
        chk("hold_iv", 32'(obs_iv), 32'd1);
    endtask

    initial begin
        int c0, c1, c2;
        #12;
        sel = 1'b0;
        reset_seq(32'h0040_0000);

        // Sequential run, 3 cycles per instruction.
        fetch(32'h0040_0000, 32'h2008_0001, 1, 0, 1'b0, 1'b0, 1'b0, 32'd1, c0);
        fetch(32'h0040_0004, 32'h3409_0002, 1, 0, 1'b0, 1'b0, 1'b0, 32'd2, c1);
        chk("thru_1", 32'(c1 - c0), 32'd3);
        fetch(32'h0040_0008, 32'h0109_5020, 1, 0, 1'b0, 1'b0, 1'b0, 32'd3, c2);
        chk("thru_2", 32'(c2 - c1), 32'd3);
        chk("next_addr_seq", obs_addr, 32'h0040_000C);

        // Reset while waiting for memory.
        tick();
        chk("in_wait_no_req", 32'(obs_req), 32'd0);
        reset_seq(32'h0040_0000);

        fetch(32'h0040_0000, 32'h1000_0003, 1, 0, 1'b1, 1'b0, 1'b1, 32'd1, c0);
        fetch(32'h0040_0010, 32'h1400_FFFB, 1, 0, 1'b0, 1'b1, 1'b0, 32'd2, c0);
        fetch(32'h0040_0000, 32'h1000_0003, 1, 0, 1'b1, 1'b0, 1'b0, 32'd3, c0);
        fetch(32'h0040_0004, 32'h2008_0005, 5, 4, 1'b0, 1'b0, 1'b0, 32'd4, c0);
        fetch(32'h0040_0008, 32'h1500_FFFE, 1, 0, 1'b0, 1'b1, 1'b0, 32'd5, c0);
        fetch(32'h0040_0004, 32'h1000_0001, 2, 1, 1'b1, 1'b1, 1'b0, 32'd6, c0);

        // Reset while an instruction is held.
        fetch_to_hold(32'h0040_000C, 32'h0109_5020);
        reset_seq(32'h0040_0000);

        // Wrap checks on the high-base instance.
        sel = 1'b1;
        reset_seq(32'hFFFF_FFF8);
        fetch(32'hFFFF_FFF8, 32'h2008_0001, 1, 0, 1'b0, 1'b0, 1'b0, 32'd1, c0);
        fetch(32'hFFFF_FFFC, 32'h3409_0002, 1, 0, 1'b0, 1'b0, 1'b0, 32'd2, c0);
        fetch(32'h0000_0000, 32'h1000_FFFE, 1, 0, 1'b1, 1'b0, 1'b1, 32'd3, c0);
        fetch(32'hFFFF_FFFC, 32'h0109_5020, 1, 0, 1'b0, 1'b0, 1'b0, 32'd4, c0);
        fetch_to_hold(32'h0000_0000, 32'h2008_0007);
        reset_seq(32'hFFFF_FFF8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
